// File: rtl/prm_scan_pkg.sv
// Shared definitions for the PRM edge scanner: default code/word widths
// and the scan controller state encoding.
package prm_scan_pkg;

    // Width of the edge/configuration code handed to the obstacle checker.
    localparam int CODE_W_DEFAULT = 15;

    // Number of mask bits packed into one output word.
    localparam int WORD_W_DEFAULT = 32;

    // Scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } scan_state_t;

endpackage

// File: rtl/prm_mask_packer.sv
// Mask bit packer: collects one mask bit per consume strobe, LSB first,
// into a word register. The word moves to an output holding register when
// it is full or when the bit is the final one of the scan. The holding
// register keeps its contents until the consumer accepts it. The caller
// only asserts consume when the holding register is empty or being
// accepted in the same cycle.
module prm_mask_packer
    import prm_scan_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      consume,
    input  logic                      mask_bit,
    input  logic                      last_bit,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic [$clog2(WORD_W):0]   out_nbits,
    output logic                      out_valid,
    output logic                      out_last
);

    localparam int POS_W   = $clog2(WORD_W);
    localparam int NBITS_W = POS_W + 1;

    logic [WORD_W-1:0] pack_reg;
    logic [POS_W-1:0]  bitpos;
    logic [WORD_W-1:0] packed_word;
    logic [WORD_W-1:0] bit_one_hot;
    logic              word_full;
    logic              word_close;

    // Word as it would look with the incoming bit placed at bitpos; bits
    // above bitpos are always zero because the register is cleared on
    // every word hand-off.
    always_comb begin
        bit_one_hot = '0;
        bit_one_hot[bitpos] = mask_bit;
        packed_word = pack_reg | bit_one_hot;
        word_full   = (bitpos == POS_W'(WORD_W - 1));
        word_close  = word_full | last_bit;
    end

    // Packing register, bit position and output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_reg  <= '0;
            bitpos    <= '0;
            out_data  <= '0;
            out_nbits <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clear) begin
            pack_reg  <= '0;
            bitpos    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (consume) begin
                if (word_close) begin
                    out_data  <= packed_word;
                    out_nbits <= NBITS_W'(bitpos) + NBITS_W'(1);
                    out_valid <= 1'b1;
                    out_last  <= last_bit;
                    pack_reg  <= '0;
                    bitpos    <= '0;
                end else begin
                    pack_reg  <= packed_word;
                    bitpos    <= bitpos + POS_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prm_edge_scan.sv
// PRM edge scanner top. Walks a range of edge codes, presents each code to
// an external combinational obstacle checker and packs the returned mask
// bits into words for a ready/valid consumer.
// Optional feature: define PRM_EDGE_SCAN_CNT_EN to add the blocked_cnt
// output, counting mask bits equal to 1 consumed during the current scan.
module prm_edge_scan
    import prm_scan_pkg::*;
#(
    parameter int CODE_W = CODE_W_DEFAULT,
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CODE_W-1:0]         start_idx,
    input  logic [CODE_W:0]           count,
    input  logic                      abort,
    output logic [CODE_W-1:0]         chk_code,
    input  logic                      chk_mask,
    output logic [WORD_W-1:0]         out_data,
    output logic [$clog2(WORD_W):0]   out_nbits,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
`ifdef PRM_EDGE_SCAN_CNT_EN
    ,
    output logic [CODE_W:0]           blocked_cnt
`endif
);

    localparam int REM_W = CODE_W + 1;

    scan_state_t       state;
    scan_state_t       state_next;
    logic [CODE_W-1:0] chk_code_next;
    logic [REM_W-1:0]  remaining;
    logic [REM_W-1:0]  remaining_next;
    logic              done_next;
    logic              consume;
    logic              last_bit;

    // The bit being consumed is the final one of the scan.
    assign last_bit = (remaining == REM_W'(1));

    assign busy = (state != ST_IDLE);

    // Next-state logic: abort overrides everything; a SCAN cycle only
    // advances when the output holding register can take a word.
    always_comb begin
        state_next     = state;
        chk_code_next  = chk_code;
        remaining_next = remaining;
        done_next      = 1'b0;
        consume        = 1'b0;
        if (abort) begin
            state_next     = ST_IDLE;
            remaining_next = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_next = 1'b1;
                        end else begin
                            chk_code_next  = start_idx;
                            remaining_next = count;
                            state_next     = ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!out_valid || out_ready) begin
                        consume        = 1'b1;
                        chk_code_next  = chk_code + CODE_W'(1);
                        remaining_next = remaining - REM_W'(1);
                        if (last_bit) begin
                            state_next = ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (out_valid && out_ready) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Controller registers: state, current code, codes left, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            chk_code  <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            chk_code  <= chk_code_next;
            remaining <= remaining_next;
            done      <= done_next;
        end
    end

    prm_mask_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (abort),
        .consume   (consume),
        .mask_bit  (chk_mask),
        .last_bit  (last_bit),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nbits (out_nbits),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

`ifdef PRM_EDGE_SCAN_CNT_EN
    logic start_ok;

    // A start is accepted only from IDLE and only when not aborted.
    assign start_ok = (state == ST_IDLE) && start && !abort;

    // Count consumed mask ones; cleared by an accepted start, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked_cnt <= '0;
        end else if (start_ok) begin
            blocked_cnt <= '0;
        end else if (consume && chk_mask) begin
            blocked_cnt <= blocked_cnt + REM_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_prm_edge_scan.sv
// Directed testbench for prm_edge_scan. A small mask model stands in for
// the obstacle checker; expected values are hand-computed per step.
module tb_prm_edge_scan;

    localparam int CODE_W = 15;
    localparam int WORD_W = 32;
    localparam int NB_W   = $clog2(WORD_W) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CODE_W-1:0] start_idx = '0;
    logic [CODE_W:0]   count = '0;
    logic              abort = 1'b0;
    logic [CODE_W-1:0] chk_code;
    logic              chk_mask;
    logic [WORD_W-1:0] out_data;
    logic [NB_W-1:0]   out_nbits;
    logic              out_last;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
`ifdef PRM_EDGE_SCAN_CNT_EN
    logic [CODE_W:0]   blocked_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mask_mode = 0;

    prm_edge_scan #(
        .CODE_W (CODE_W),
        .WORD_W (WORD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_idx (start_idx),
        .count     (count),
        .abort     (abort),
        .chk_code  (chk_code),
        .chk_mask  (chk_mask),
        .out_data  (out_data),
        .out_nbits (out_nbits),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
`ifdef PRM_EDGE_SCAN_CNT_EN
        ,
        .blocked_cnt (blocked_cnt)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Obstacle checker model: mask bit as a function of the presented code.
    always_comb begin
        chk_mask = 1'b0;
        case (mask_mode)
            0: chk_mask = chk_code[0];
            1: chk_mask = 1'b1;
            2: chk_mask = (chk_code >= 15'h0400) && (chk_code < 15'h0407);
            default: chk_mask = 1'b0;
        endcase
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no end of test, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [CODE_W-1:0] idx, input logic [CODE_W:0] cnt);
        start_idx = idx;
        count     = cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid) break;
            tick();
        end
        checkOutput({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        $display("[TB] prm_edge_scan directed test starting");

        // Reset state
        tick();
        tick();
        checkOutput("rst_chk_code", 64'(chk_code), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_nbits", 64'(out_nbits), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Full 32-bit word, mask = code[0]
        mask_mode = 0;
        out_ready = 1'b1;
        applyStimulus(15'h0010, 16'd32);
        checkOutput("w32_busy", 64'(busy), 64'd1);
        checkOutput("w32_first_code", 64'(chk_code), 64'h0010);
        waitValid("w32", 40);
        checkOutput("w32_data", 64'(out_data), 64'hAAAAAAAA);
        checkOutput("w32_nbits", 64'(out_nbits), 64'd32);
        checkOutput("w32_last", 64'(out_last), 64'd1);
        checkOutput("w32_done_early", 64'(done), 64'd0);
        tick();
        checkOutput("w32_done", 64'(done), 64'd1);
        checkOutput("w32_busy_end", 64'(busy), 64'd0);
        checkOutput("w32_valid_end", 64'(out_valid), 64'd0);
        tick();
        checkOutput("w32_done_pulse", 64'(done), 64'd0);

        // Code wrap-around 7FFE..0001
        applyStimulus(15'h7FFE, 16'd4);
        checkOutput("wrap_code0", 64'(chk_code), 64'h7FFE);
        tick();
        checkOutput("wrap_code1", 64'(chk_code), 64'h7FFF);
        tick();
        checkOutput("wrap_code2", 64'(chk_code), 64'h0000);
        tick();
        checkOutput("wrap_code3", 64'(chk_code), 64'h0001);
        tick();
        checkOutput("wrap_valid", 64'(out_valid), 64'd1);
        checkOutput("wrap_data", 64'(out_data), 64'hA);
        checkOutput("wrap_nbits", 64'(out_nbits), 64'd4);
        checkOutput("wrap_last", 64'(out_last), 64'd1);
        tick();
        checkOutput("wrap_done", 64'(done), 64'd1);
        tick();

        // Backpressure: 40 codes, all ones, consumer stalls 5 cycles
        mask_mode = 1;
        out_ready = 1'b0;
        applyStimulus(15'h0100, 16'd40);
        waitValid("stall_w0", 40);
        checkOutput("stall_w0_data", 64'(out_data), 64'hFFFFFFFF);
        checkOutput("stall_w0_nbits", 64'(out_nbits), 64'd32);
        checkOutput("stall_w0_last", 64'(out_last), 64'd0);
        checkOutput("stall_code_at_valid", 64'(chk_code), 64'h0120);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_code_frozen", 64'(chk_code), 64'h0120);
            checkOutput("stall_data_held", 64'(out_data), 64'hFFFFFFFF);
            checkOutput("stall_valid_held", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("stall_release_valid", 64'(out_valid), 64'd0);
        checkOutput("stall_release_code", 64'(chk_code), 64'h0121);
        waitValid("stall_w1", 12);
        checkOutput("stall_w1_data", 64'(out_data), 64'h000000FF);
        checkOutput("stall_w1_nbits", 64'(out_nbits), 64'd8);
        checkOutput("stall_w1_last", 64'(out_last), 64'd1);
        tick();
        checkOutput("stall_done", 64'(done), 64'd1);
        tick();

        // Zero-length scan
        applyStimulus(15'h0055, 16'd0);
        checkOutput("zero_done", 64'(done), 64'd1);
        checkOutput("zero_busy", 64'(busy), 64'd0);
        checkOutput("zero_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("zero_done_pulse", 64'(done), 64'd0);
        checkOutput("zero_valid_after", 64'(out_valid), 64'd0);

        // Abort mid-scan, then restart from a new index
        mask_mode = 0;
        applyStimulus(15'h0200, 16'd100);
        for (int i = 0; i < 10; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("abort_no_done", 64'(done), 64'd0);
        end
        applyStimulus(15'h0300, 16'd2);
        checkOutput("restart_code0", 64'(chk_code), 64'h0300);
        checkOutput("restart_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("restart_code1", 64'(chk_code), 64'h0301);
        tick();
        checkOutput("restart_valid", 64'(out_valid), 64'd1);
        checkOutput("restart_data", 64'(out_data), 64'h2);
        checkOutput("restart_nbits", 64'(out_nbits), 64'd2);
        checkOutput("restart_last", 64'(out_last), 64'd1);
        tick();
        checkOutput("restart_done", 64'(done), 64'd1);
        tick();

        // Reset mid-scan discards everything
        applyStimulus(15'h0500, 16'd32);
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_chk_code", 64'(chk_code), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_out_data", 64'(out_data), 64'd0);
        checkOutput("midrst_out_nbits", 64'(out_nbits), 64'd0);
        checkOutput("midrst_out_last", 64'(out_last), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
`ifdef PRM_EDGE_SCAN_CNT_EN
        checkOutput("midrst_blocked_cnt", 64'(blocked_cnt), 64'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        checkOutput("postrst_valid", 64'(out_valid), 64'd0);

        // 32 codes with exactly seven mask ones (codes 0x400..0x406)
        mask_mode = 2;
        applyStimulus(15'h0400, 16'd32);
        waitValid("cnt", 40);
        checkOutput("cnt_data", 64'(out_data), 64'h7F);
        checkOutput("cnt_nbits", 64'(out_nbits), 64'd32);
        checkOutput("cnt_last", 64'(out_last), 64'd1);
        tick();
        checkOutput("cnt_done", 64'(done), 64'd1);
`ifdef PRM_EDGE_SCAN_CNT_EN
        checkOutput("cnt_blocked_at_done", 64'(blocked_cnt), 64'd7);
        tick();
        checkOutput("cnt_blocked_held", 64'(blocked_cnt), 64'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
